pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised ready/valid pipeline stage register for the CPU datapath. It replaces the fixed IR/PC/r1/r2 plus 7-control-bit stage latches with one generic block. It carries NUM_DATA data words and CTRL_W control bits per stage, with backpressure, synchronous flush and bubble masking. It is instantiated between every pair of pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
Parameters:
- DATA_W, 32, width of each data word
- NUM_DATA, 4, number of data words per entry (IR, PC, r1, r2 by default)
- CTRL_W, 7, number of control bits per entry (mtr, rd, jal, srav, sb, rw, mw by default)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous discard of all held entries and any same-cycle input
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept this cycle
- in_data  in  NUM_DATA*DATA_W  data words, word k at bits [k*DATA_W +: DATA_W]
- in_ctrl  in  CTRL_W  control bits
- out_valid  out  1  entry available downstream
- out_ready  in  1  downstream accepts this cycle
- out_data  out  NUM_DATA*DATA_W  held data words
- out_ctrl  out  CTRL_W  held control bits, forced to 0 whenever out_valid=0

## Operation
- accept = in_valid & in_ready; pop = out_valid & out_ready.
- Two slots: main (drives outputs) and skid.
- States: EMPTY (neither slot valid), ONE (main valid), TWO (main and skid valid).
- in_ready = (state != TWO). It is a registered signal with no combinational path from out_ready.
- Transitions from EMPTY:
  - accept -> ONE, main <= in.
- Transitions from ONE:
  - accept & pop -> ONE, main <= in.
  - accept & ~pop -> TWO, skid <= in.
  - ~accept & pop -> EMPTY.
  - Otherwise stay in ONE.
- Transitions from TWO:
  - pop -> ONE, main <= skid.
  - Otherwise stay in TWO. in_ready=0, so no accept is possible.
- Priority is rst > flush > handshake. On either rst or flush, the next state is EMPTY, and both slots' data and ctrl are cleared to 0.
- Entries leave in arrival order. No entry is duplicated or dropped except by flush or rst.
- out_data holds the last value after draining to EMPTY. out_ctrl reads 0 in EMPTY, so it behaves as a NOP bubble.

## Timing
- Reset values: out_valid=0, out_data=0, out_ctrl=0, in_ready=1 (the cycle after rst).
- Latency is 1 cycle: an entry accepted at edge N is visible on out_* after edge N.
- Throughput is 1 entry/cycle while out_ready=1.
- When out_ready drops, at most one further entry is absorbed into skid. in_ready falls after the edge that filled skid.
- A flush asserted in the same cycle as accept discards that input. out_valid=0 and in_ready=1 after the edge.
- An rst mid-stream (any state) gives EMPTY after the edge, whatever the handshake inputs are.
- If out_ready toggles while out_valid=0, state is unchanged.

## Configuration
- Macro: PIPE_STAGE_SKID_EN.
- Defined: the two-slot behaviour above; in_ready is registered.
- Undefined: main slot only, and the TWO state does not exist.
  - in_ready = ~out_valid | out_ready. This is combinational from out_ready.
  - accept loads main.
  - pop & ~accept goes to EMPTY.
  - Latency, reset and flush behaviour are identical.

## Structure
- Shared package pipe_stage_pkg holds:
  - state enum (ST_EMPTY, ST_ONE, ST_TWO);
  - default word indices IR_IDX=0, PC_IDX=1, R1_IDX=2, R2_IDX=3;
  - control bit positions MW_BIT=0, RW_BIT=1, SB_BIT=2, SRAV_BIT=3, JAL_BIT=4, RD_BIT=5, MTR_BIT=6.
- Sub-module pipe_stage_slot:
  - a clearable, loadable register of width NUM_DATA*DATA_W+CTRL_W;
  - ports: clk, clr, load, din, dout; clr takes priority over load;
  - instantiated once for main and once for skid (skid only under PIPE_STAGE_SKID_EN).
- The top level holds the state register and the handshake logic.

## Test plan
- Reset: hold rst=1 for 2 cycles with in_valid=1 and in_ctrl=7'h7F -> out_valid=0, out_ctrl=0, out_data=0, in_ready=1.
- Streaming: out_ready=1, push IR words 32'h1,32'h2,32'h3 on consecutive cycles -> same words on out_data one cycle later each, no gaps.
- Backpressure: push 32'hA,32'hB, drop out_ready at B's acceptance -> state TWO, in_ready=0; raise out_ready -> A then B delivered, no loss. Without the macro: in_ready follows out_ready combinationally, and B is held off.
- Flush: state TWO with pending 32'hC, assert flush with in_valid=1 and 32'hD -> next cycle out_valid=0, out_ctrl=0, in_ready=1; C and D never appear.
- Bubble: drain to EMPTY after delivering ctrl 7'h41 -> out_ctrl=0 and out_data retains the last word.
- Width scaling: DATA_W=64, NUM_DATA=2, CTRL_W=3, random ready/valid for 1000 cycles -> a scoreboard sees the output sequence equal to the accepted sequence.

Source files
------------

// File: rtl/pipe_stage_pkg.sv
// pipe_stage_pkg
//   Shared definitions for the generic ready/valid pipeline stage register.
//   - state_e : occupancy state of a stage (EMPTY / ONE / TWO)
//   - *_IDX   : default data-word positions inside an entry (IR, PC, r1, r2)
//   - *_BIT   : default control-bit positions inside an entry
//   - stage_full() : true when both slots are occupied
package pipe_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // neither slot valid
    ST_ONE   = 2'd1,  // main valid
    ST_TWO   = 2'd2   // main and skid valid
  } state_e;

  // Default data-word indices: word k sits at bits [k*DATA_W +: DATA_W]
  localparam int IR_IDX = 0;
  localparam int PC_IDX = 1;
  localparam int R1_IDX = 2;
  localparam int R2_IDX = 3;

  // Default control-bit positions
  localparam int MW_BIT   = 0;
  localparam int RW_BIT   = 1;
  localparam int SB_BIT   = 2;
  localparam int SRAV_BIT = 3;
  localparam int JAL_BIT  = 4;
  localparam int RD_BIT   = 5;
  localparam int MTR_BIT  = 6;

  function automatic logic stage_full(input state_e s);
    return s == ST_TWO;
  endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// pipe_stage_slot
//   Clearable, loadable register holding one pipeline entry.
//   Ports:
//     clk  : clock, rising edge
//     clr  : synchronous clear to 0, wins over load
//     load : capture din on the next edge
//     din  : entry to capture (W bits)
//     dout : held entry (W bits)
module pipe_stage_slot #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] dout_d, dout_q;

  always_comb begin
    dout_d = dout_q;
    if (clr)       dout_d = '0;
    else if (load) dout_d = din;
  end

  always_ff @(posedge clk) begin
    dout_q <= dout_d;
  end

  assign dout = dout_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Generic ready/valid stage register placed between CPU pipeline stages.
//   Each entry carries NUM_DATA words of DATA_W bits plus CTRL_W control bits.
//   Build option PIPE_STAGE_SKID_EN:
//     defined   : main + skid slot, in_ready is a flop (no path from out_ready)
//     undefined : main slot only, in_ready = ~out_valid | out_ready
//   Ports:
//     clk, rst         : clock; synchronous active-high reset
//     flush            : synchronous discard of held entries and same-cycle input
//     in_valid/in_ready: upstream handshake
//     in_data, in_ctrl : incoming entry (word k at [k*DATA_W +: DATA_W])
//     out_valid/out_ready: downstream handshake
//     out_data         : main slot data (holds last value when empty)
//     out_ctrl         : main slot control, forced to 0 when out_valid=0
module pipe_stage_reg
  import pipe_stage_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_DATA = 4,
  parameter int CTRL_W   = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0]          in_ctrl,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0]          out_ctrl
);

  localparam int ENT_W = NUM_DATA*DATA_W + CTRL_W;

  state_e             state_d, state_q;
  logic               accept, pop, clr;
  logic               main_load;
  logic [ENT_W-1:0]   main_din, main_dout;

  // Slots are cleared by either reset or flush; rst additionally forces the
  // state flops below, so rst > flush > handshake falls out naturally.
  assign clr       = rst | flush;
  assign out_valid = (state_q != ST_EMPTY);
  assign pop       = out_valid & out_ready;
  assign accept    = in_valid & in_ready;

`ifdef PIPE_STAGE_SKID_EN

  logic             in_ready_d, in_ready_q;
  logic             skid_load;
  logic [ENT_W-1:0] skid_dout;

  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    main_din  = {in_data, in_ctrl};
    skid_load = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d   = ST_ONE;
          main_load = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          main_load = 1'b1;
        end else if (accept) begin
          // Downstream stalled: park the new entry behind main
          state_d   = ST_TWO;
          skid_load = 1'b1;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so only a pop can move us
        if (pop) begin
          state_d   = ST_ONE;
          main_load = 1'b1;
          main_din  = skid_dout;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
    // Registered ready: computed from the next state, not from out_ready
    in_ready_d = ~stage_full(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;

  pipe_stage_slot #(.W(ENT_W)) u_skid (
    .clk  (clk),
    .clr  (clr),
    .load (skid_load),
    .din  ({in_data, in_ctrl}),
    .dout (skid_dout)
  );

`else

  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    main_din  = {in_data, in_ctrl};
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d   = ST_ONE;
          main_load = 1'b1;
        end
      end
      ST_ONE: begin
        // accept here implies pop (in_ready needs out_ready when full)
        if (accept)   main_load = 1'b1;
        else if (pop) state_d   = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  assign in_ready = ~out_valid | out_ready;

`endif

  pipe_stage_slot #(.W(ENT_W)) u_main (
    .clk  (clk),
    .clr  (clr),
    .load (main_load),
    .din  (main_din),
    .dout (main_dout)
  );

  assign out_data = main_dout[ENT_W-1:CTRL_W];
  // Empty stage presents an all-zero control word, i.e. a NOP bubble
  assign out_ctrl = out_valid ? main_dout[CTRL_W-1:0] : '0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
//   Two instances share one stimulus stream: A at default widths (4x32, ctrl 7)
//   and B at 2x64, ctrl 3 (same 128-bit data bus). The expected behaviour is
//   an in-order queue of accepted entries; both instances are compared to it
//   on every negative edge. Directed sections add literal expectations.
module tb_pipe_stage_reg;

  localparam int TW  = 128;
  localparam int CW  = 7;
  localparam int CWB = 3;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [TW-1:0] in_data;
  logic [CW-1:0] in_ctrl;

  logic           a_in_ready, a_out_valid;
  logic [TW-1:0]  a_out_data;
  logic [CW-1:0]  a_out_ctrl;
  logic           b_in_ready, b_out_valid;
  logic [TW-1:0]  b_out_data;
  logic [CWB-1:0] b_out_ctrl;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(32), .NUM_DATA(4), .CTRL_W(CW)) dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data), .out_ctrl(a_out_ctrl)
  );

  pipe_stage_reg #(.DATA_W(64), .NUM_DATA(2), .CTRL_W(CWB)) dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_ctrl(in_ctrl[CWB-1:0]),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl)
  );

  typedef struct packed {
    logic [TW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  ent_t          q[$];
  logic [TW-1:0] last_d = '0;
  bit            armed = 1'b0;
  int            compared = 0, mismatched = 0;

  // Can the stage take an entry this cycle, judged from queue occupancy.
  function automatic bit m_ready();
    if (SKID) return q.size() < 2;
    else      return (q.size() == 0) || out_ready;
  endfunction

  task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model update on each rising edge (inputs are stable here)
  initial forever begin
    bit acc, pp;
    @(posedge clk);
    if (rst || flush) begin
      q.delete();
      last_d = '0;
      if (rst) armed = 1'b1;
    end else begin
      acc = in_valid && m_ready();
      pp  = (q.size() > 0) && out_ready;
      if (pp) begin
        last_d = q[0].d;
        void'(q.pop_front());
      end
      if (acc) q.push_back('{d: in_data, c: in_ctrl});
    end
  end

  // Per-cycle comparison against the model
  initial forever begin
    ent_t h;
    bit   v;
    @(negedge clk);
    if (armed) begin
      v = q.size() > 0;
      h = v ? q[0] : '{d: last_d, c: '0};
      chk("a_out_valid", TW'(a_out_valid), TW'(v));
      chk("a_out_data",  a_out_data,       h.d);
      chk("a_out_ctrl",  TW'(a_out_ctrl),  TW'(h.c));
      chk("a_in_ready",  TW'(a_in_ready),  TW'(m_ready()));
      chk("b_out_valid", TW'(b_out_valid), TW'(v));
      chk("b_out_data",  b_out_data,       h.d);
      chk("b_out_ctrl",  TW'(b_out_ctrl),  TW'(h.c[CWB-1:0]));
      chk("b_in_ready",  TW'(b_in_ready),  TW'(m_ready()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic [CW-1:0] c);
    in_valid = v;
    in_data  = TW'(w);
    in_ctrl  = c;
  endtask

  initial begin
    bit acc_b;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 7'h7F; in_data = {4{32'hDEADBEEF}};

    // Reset held two edges with a live input
    step(); step();
    @(negedge clk);
    chk("rst_valid", TW'(a_out_valid), TW'(1'b0));
    chk("rst_ctrl",  TW'(a_out_ctrl),  TW'(7'h00));
    chk("rst_data",  a_out_data,       TW'(0));
    chk("rst_ready", TW'(a_in_ready),  TW'(1'b1));

    // Streaming 1,2,3 with downstream always ready
    step(); rst = 1'b0; out_ready = 1'b1; drive(1'b1, 32'h1, 7'h00);
    step(); drive(1'b1, 32'h2, 7'h00);
    @(negedge clk);
    chk("s1_word",  TW'(a_out_data[31:0]), TW'(32'h1));
    chk("s1_valid", TW'(a_out_valid),      TW'(1'b1));
    step(); drive(1'b1, 32'h3, 7'h41);
    @(negedge clk);
    chk("s2_word",  TW'(a_out_data[31:0]), TW'(32'h2));
    step(); drive(1'b0, 32'h0, 7'h00);
    @(negedge clk);
    chk("s3_word",  TW'(a_out_data[31:0]), TW'(32'h3));
    chk("s3_ctrl",  TW'(a_out_ctrl),       TW'(7'h41));
    // Bubble after drain
    step();
    @(negedge clk);
    chk("bub_valid", TW'(a_out_valid),      TW'(1'b0));
    chk("bub_ctrl",  TW'(a_out_ctrl),       TW'(7'h00));
    chk("bub_word",  TW'(a_out_data[31:0]), TW'(32'h3));

    // Backpressure: A accepted, downstream stalls while B is offered
    step(); drive(1'b1, 32'hA, 7'h01);
    step(); out_ready = 1'b0; drive(1'b1, 32'hB, 7'h02);
    @(negedge clk);
    chk("bp_ready_pre", TW'(a_in_ready), TW'(SKID));
    acc_b = m_ready();
    step(); if (acc_b) in_valid = 1'b0;
    @(negedge clk);
    chk("bp_word_a",  TW'(a_out_data[31:0]), TW'(32'hA));
    chk("bp_ready_0", TW'(a_in_ready),       TW'(1'b0));
    step(); out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_rise", TW'(a_in_ready), TW'(!SKID));
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk("bp_word_b",  TW'(a_out_data[31:0]), TW'(32'hB));
    chk("bp_valid_b", TW'(a_out_valid),      TW'(1'b1));
    step();
    @(negedge clk);
    chk("bp_drained", TW'(a_out_valid), TW'(1'b0));

    // Flush with a pending C and a same-cycle D
    step(); out_ready = 1'b0; drive(1'b1, 32'h5, 7'h05);
    step(); drive(1'b1, 32'hC, 7'h0C);
    step(); flush = 1'b1; drive(1'b1, 32'hD, 7'h0D);
    @(negedge clk);
    chk("fl_pre_ready", TW'(a_in_ready), TW'(1'b0));
    step(); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("fl_valid", TW'(a_out_valid), TW'(1'b0));
    chk("fl_ctrl",  TW'(a_out_ctrl),  TW'(7'h00));
    chk("fl_ready", TW'(a_in_ready),  TW'(1'b1));
    chk("fl_data",  a_out_data,       TW'(0));
    step(); step();
    @(negedge clk);
    chk("fl_after", TW'(a_out_valid), TW'(1'b0));

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 1000; i++) begin
      step();
      rst       = ($urandom_range(199) == 0);
      flush     = ($urandom_range(63) == 0);
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      in_ctrl   = CW'($urandom);
    end
    step(); rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    step();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
